uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with input FIFO; successor to the fixed 8N1 sender.
//  - Accepts words on a valid/ready handshake and buffers up to FIFO_DEPTH of them.
//  - Serialises each word LSB-first as start, data, optional parity, then 1 or 2 stop bits.
//  - Sits between the CPU output port and the board TX pin; lets the CPU burst bytes without polling per byte.
// PARAMETERS
//  CLKS_PER_BIT  32'h28B0  CLK cycles per serial bit (>=2); each bit lasts exactly this many cycles
//  DATA_BITS     8         data bits per frame, 5..9
//  PARITY        0         0 = none, 1 = odd, 2 = even
//  STOP_BITS     1         1 or 2
//  FIFO_DEPTH    4         FIFO entries, power of two, >=2
// PORTS
//  CLK         in   1                     clock, all logic on rising edge
//  RESET_N     in   1                     asynchronous active-low reset
//  data        in   DATA_BITS             word to send
//  valid       in   1                     data valid; word accepted on a CLK edge where valid & ready
//  ready       out  1                     FIFO not full (= ~full)
//  UART_TX     out  1                     serial line, idles high, registered
//  busy        out  1                     1 while a frame is on the line or the FIFO is non-empty
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered, excluding the frame on the line
// BEHAVIOUR
//  Reset (RESET_N=0, async): UART_TX=1, busy=0, ready=1, fifo_count=0, FSM=IDLE, FIFO flushed.
//  - A frame in progress is abandoned.
//  - The line returns high immediately, without waiting for a clock edge.
//  FIFO
//  - Push when valid & ready. Pop when the FSM loads a word.
//  - ready depends only on full: no push while full, even on a cycle that also pops.
//  - Push and pop on the same edge with 0 < count < DEPTH: count unchanged, order preserved.
//  - Pointers wrap modulo FIFO_DEPTH. count=DEPTH -> ready=0.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//  - IDLE: UART_TX=1. If FIFO non-empty, pop the head into the shift register and go to START.
//  - START: UART_TX=0 for CLKS_PER_BIT cycles.
//  - DATA: bit i (i=0..DATA_BITS-1, LSB first) for CLKS_PER_BIT cycles each.
//  - PARITY (skipped when PARITY=0): odd mode sends ~^word, even mode sends ^word.
//  - STOP: UART_TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  - At the end of STOP: if FIFO non-empty, pop and enter START on the same edge (zero idle gap); else go to IDLE.
//  Bit timer
//  - Counter runs 0..CLKS_PER_BIT-1 and advances the state or bit index when it reaches CLKS_PER_BIT-1.
//  - Width is 32 bits; no off-by-one: each bit is exactly CLKS_PER_BIT cycles.
//  Latency
//  - Word pushed at edge N into an empty FIFO with FSM in IDLE -> popped at edge N+1.
//  - UART_TX falls after edge N+1.
//  - fifo_count reads 1 after edge N and 0 after edge N+1.
//  Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
//  busy = (state!=IDLE) | (count!=0). It falls on the same edge the FSM returns to IDLE with an empty FIFO.
//  The word on the line is held in the shift register. data may change after acceptance without affecting that frame.
//  Illegal parameter values stop elaboration via $error.
// TESTING (bench uses CLKS_PER_BIT=4 unless stated)
//  1 Reset, DATA_BITS=8, PARITY=0, STOP_BITS=1: push 8'hA5 -> UART_TX low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; busy high for 40 cycles, then 0.
//  2 PARITY=2, push 8'h07 -> parity bit=1. PARITY=1, push 8'h07 -> parity bit=0. STOP_BITS=2 -> stop high 8 cycles.
//  3 FIFO_DEPTH=4: hold valid with 6 words, first popped immediately -> ready=0 once fifo_count=4; all 6 words sent in order, back-to-back, no idle cycle between stop and next start.
//  4 Push and pop on the same edge at fifo_count=2 -> fifo_count stays 2. Push while full -> word dropped, not sent.
//  5 Assert RESET_N=0 mid-DATA with 3 words queued -> UART_TX=1 before the next CLK edge, fifo_count=0; after release, line stays idle until a new push.
//  6 DATA_BITS=5, CLKS_PER_BIT=2, push 5'h1F -> frame of 14 cycles, and upper data bits are ignored.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Word handshake between the CPU output port and the UART transmitter.
// Master offers data/valid, the transmitter answers with ready.
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// A queued word starts on the edge its predecessor's last stop bit ends, so bursts leave no idle gap.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 32'h28B0,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   uart_tx_fifo_if.slave               in_if,
   output logic                        UART_TX,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CW        = AW + 1;
   localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY > 2) begin : g_bad_par
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   state_t               state_q, state_d;
   logic [31:0]          timer_q, timer_d;
   logic [3:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;

   logic                 full, push, pop, bit_end;
   logic [DATA_BITS-1:0] head;

   // FIFO bookkeeping; pop is raised by the FSM below
   always_comb begin
      full     = (count_q == CW'(FIFO_DEPTH));
      push     = in_if.valid & ~full;
      head     = mem_q[rd_ptr_q];
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= in_if.data;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      pop     = 1'b0;
      bit_end = (timer_q == BIT_LAST);
      timer_d = bit_end ? '0 : timer_q + 32'd1;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (count_q != '0) pop = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               idx_d   = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (idx_q == STOP_LAST) begin
                  if (count_q != '0) pop = 1'b1;
                  else               state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Loading latches the whole word, so later changes on data cannot corrupt this frame
      if (pop) begin
         state_d = S_START;
         timer_d = '0;
         idx_d   = '0;
         shreg_d = head;
         par_d   = (PARITY == 1) ? ~^head : ^head;
      end

      // Line level follows the next state so UART_TX is a clean flop output
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= S_IDLE;
         timer_q  <= '0;
         idx_q    <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
      end
   end

   assign in_if.ready = ~full;
   assign UART_TX     = tx_q;
   assign busy        = (state_q != S_IDLE) | (count_q != '0);
   assign fifo_count  = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, even/odd parity, 2 stop bits
// and a 5-bit, 2-clock-per-bit configuration.
module tb_uart_tx_fifo;
   logic CLK = 1'b0;
   logic RESET_N = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 CLK = ~CLK;

   uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
   uart_tx_fifo_if #(.DATA_BITS(8)) ife ();
   uart_tx_fifo_if #(.DATA_BITS(8)) ifo ();
   uart_tx_fifo_if #(.DATA_BITS(5)) ifs ();

   logic       tx0, txe, txo, txs;
   logic       busy0, busye, busyo, busys;
   logic [2:0] cnt0, cnte, cnto, cnts;

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .CLK(CLK), .RESET_N(RESET_N), .in_if(if0), .UART_TX(tx0), .busy(busy0), .fifo_count(cnt0));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) ue (
      .CLK(CLK), .RESET_N(RESET_N), .in_if(ife), .UART_TX(txe), .busy(busye), .fifo_count(cnte));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) uo (
      .CLK(CLK), .RESET_N(RESET_N), .in_if(ifo), .UART_TX(txo), .busy(busyo), .fifo_count(cnto));
   uart_tx_fifo #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) us (
      .CLK(CLK), .RESET_N(RESET_N), .in_if(ifs), .UART_TX(txs), .busy(busys), .fifo_count(cnts));

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      #1 RESET_N = 1'b0;
      #2;
      total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx0); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy0); end
      total++; if (if0.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", if0.ready); end
      total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt0); end
      total++; if ({txe, txo, txs} !== 3'b111) begin bad++; $display("FAIL reset_tx_all got=%b want=111", {txe, txo, txs}); end
      @(negedge CLK);
      RESET_N = 1'b1;
      step();
      step();
   endtask

   // 8N1, 0xA5: start, 1,0,1,0,0,1,0,1, stop
   task automatic test_basic();
      logic [9:0] fr;
      fr = 10'b1_10100101_0;
      if0.data = 8'hA5; if0.valid = 1'b1;
      step();
      if0.valid = 1'b0; if0.data = 8'h00;
      total++; if (cnt0 !== 3'd1) begin bad++; $display("FAIL basic_count_push got=%0d want=1", cnt0); end
      total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL basic_tx_before_pop got=%b want=1", tx0); end
      for (int k = 0; k < 40; k++) begin
         step();
         if (k == 0) begin
            total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL basic_count_pop got=%0d want=0", cnt0); end
         end
         total++; if (tx0 !== fr[k/4]) begin bad++; $display("FAIL basic_tx k=%0d got=%b want=%b", k, tx0, fr[k/4]); end
         total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy k=%0d got=%b want=1", k, busy0); end
      end
      step();
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy0); end
      total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL basic_tx_end got=%b want=1", tx0); end
   endtask

   // 0x07: even parity bit 1 with one stop; odd parity bit 0 with two stops
   task automatic test_parity();
      logic [10:0] fe;
      logic [11:0] fo;
      fe = 11'b1_1_00000111_0;
      fo = 12'b11_0_00000111_0;
      ife.data = 8'h07; ife.valid = 1'b1;
      ifo.data = 8'h07; ifo.valid = 1'b1;
      step();
      ife.valid = 1'b0; ifo.valid = 1'b0;
      for (int k = 0; k < 48; k++) begin
         step();
         if (k < 44) begin
            total++; if (txe !== fe[k/4]) begin bad++; $display("FAIL even_tx k=%0d got=%b want=%b", k, txe, fe[k/4]); end
         end
         if (k == 44) begin
            total++; if (busye !== 1'b0) begin bad++; $display("FAIL even_busy_end got=%b want=0", busye); end
         end
         total++; if (txo !== fo[k/4]) begin bad++; $display("FAIL odd_tx k=%0d got=%b want=%b", k, txo, fo[k/4]); end
         total++; if (busyo !== 1'b1) begin bad++; $display("FAIL odd_busy k=%0d got=%b want=1", k, busyo); end
      end
      step();
      total++; if (busyo !== 1'b0) begin bad++; $display("FAIL odd_busy_end got=%b want=0", busyo); end
   endtask

   // Six words offered with valid held; source advances only on an accepted handshake
   task automatic test_burst();
      logic [7:0] w [6];
      logic [9:0] fr;
      logic       line [$];
      int         nacc;
      bit         rdy, saw_full, started;
      w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      nacc = 0; saw_full = 0; started = 0;
      if0.data = w[0]; if0.valid = 1'b1;
      rdy = if0.ready;
      for (int c = 0; c < 320 && line.size() < 241; c++) begin
         step();
         if (rdy && if0.valid) nacc++;
         if0.valid = (nacc < 6);
         if0.data  = w[(nacc < 6) ? nacc : 5];
         rdy = if0.ready;
         if (cnt0 == 3'd4) begin
            saw_full = 1;
            total++; if (if0.ready !== 1'b0) begin bad++; $display("FAIL burst_ready_full got=%b want=0", if0.ready); end
         end
         if (!started && tx0 === 1'b0) started = 1;
         if (started) line.push_back(tx0);
      end
      if0.valid = 1'b0;
      total++; if (nacc != 6) begin bad++; $display("FAIL burst_accepted got=%0d want=6", nacc); end
      total++; if (!saw_full) begin bad++; $display("FAIL burst_full got=0 want=1"); end
      total++; if (line.size() != 241) begin bad++; $display("FAIL burst_len got=%0d want=241", line.size()); end
      if (line.size() == 241) begin
         for (int i = 0; i < 240; i++) begin
            fr = {1'b1, w[i/40], 1'b0};
            total++; if (line[i] !== fr[(i%40)/4]) begin bad++; $display("FAIL burst_tx i=%0d got=%b want=%b", i, line[i], fr[(i%40)/4]); end
         end
      end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL burst_busy_end got=%b want=0", busy0); end
   endtask

   // Simultaneous push/pop at count 2, then a push while full that must be dropped
   task automatic test_fifo_edges();
      logic [7:0] w [6];
      logic [9:0] fr;
      w = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
      for (int e = 0; e <= 241; e++) begin
         if0.valid = 1'b1;
         case (e)
            0:  if0.data = w[0];
            1:  if0.data = w[1];
            2:  if0.data = w[2];
            41: if0.data = w[3];
            42: if0.data = w[4];
            43: if0.data = w[5];
            44: if0.data = 8'hEE;
            default: if0.valid = 1'b0;
         endcase
         step();
         if (e == 2 || e == 40 || e == 41) begin
            total++; if (cnt0 !== 3'd2) begin bad++; $display("FAIL edge_count e=%0d got=%0d want=2", e, cnt0); end
         end
         if (e == 43 || e == 44) begin
            total++; if (cnt0 !== 3'd4) begin bad++; $display("FAIL edge_full_count e=%0d got=%0d want=4", e, cnt0); end
            total++; if (if0.ready !== 1'b0) begin bad++; $display("FAIL edge_ready e=%0d got=%b want=0", e, if0.ready); end
         end
         if (e >= 1 && e <= 240) begin
            fr = {1'b1, w[(e-1)/40], 1'b0};
            total++; if (tx0 !== fr[((e-1)%40)/4]) begin bad++; $display("FAIL edge_tx e=%0d got=%b want=%b", e, tx0, fr[((e-1)%40)/4]); end
         end
         if (e == 241) begin
            total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL edge_busy_end got=%b want=0", busy0); end
            total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL edge_count_end got=%0d want=0", cnt0); end
         end
      end
      if0.valid = 1'b0;
   endtask

   // Asynchronous reset in the middle of a data bit with three words queued
   task automatic test_reset_mid();
      for (int e = 0; e <= 10; e++) begin
         if0.valid = (e < 4);
         if0.data  = 8'h00;
         step();
      end
      total++; if (cnt0 !== 3'd3) begin bad++; $display("FAIL mid_count_pre got=%0d want=3", cnt0); end
      total++; if (tx0 !== 1'b0) begin bad++; $display("FAIL mid_tx_pre got=%b want=0", tx0); end
      #2 RESET_N = 1'b0;
      #1;
      total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL mid_tx_async got=%b want=1", tx0); end
      total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL mid_count_async got=%0d want=0", cnt0); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy_async got=%b want=0", busy0); end
      total++; if (if0.ready !== 1'b1) begin bad++; $display("FAIL mid_ready_async got=%b want=1", if0.ready); end
      @(negedge CLK);
      RESET_N = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         total++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL mid_idle k=%0d got=%b%b want=10", k, tx0, busy0); end
      end
      if0.data = 8'h3C; if0.valid = 1'b1;
      step();
      if0.valid = 1'b0;
      total++; if (cnt0 !== 3'd1 || tx0 !== 1'b1) begin bad++; $display("FAIL mid_push got=%0d/%b want=1/1", cnt0, tx0); end
      step();
      total++; if (cnt0 !== 3'd0 || tx0 !== 1'b0) begin bad++; $display("FAIL mid_start got=%0d/%b want=0/0", cnt0, tx0); end
      for (int k = 0; k < 40; k++) step();
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy_end got=%b want=0", busy0); end
   endtask

   // 5 data bits, 2 clocks per bit: 7-bit frame, 14 cycles
   task automatic test_small();
      logic [6:0] fr;
      fr = 7'b1_11111_0;
      ifs.data = 5'h1F; ifs.valid = 1'b1;
      step();
      ifs.valid = 1'b0; ifs.data = 5'h00;
      for (int k = 0; k < 15; k++) begin
         step();
         if (k < 14) begin
            total++; if (txs !== fr[k/2]) begin bad++; $display("FAIL small_tx k=%0d got=%b want=%b", k, txs, fr[k/2]); end
         end
         if (k == 13) begin
            total++; if (busys !== 1'b1) begin bad++; $display("FAIL small_busy_last got=%b want=1", busys); end
         end
         if (k == 14) begin
            total++; if (busys !== 1'b0 || txs !== 1'b1) begin bad++; $display("FAIL small_end got=%b/%b want=0/1", busys, txs); end
         end
      end
   endtask

   initial begin
      if0.valid = 1'b0; if0.data = '0;
      ife.valid = 1'b0; ife.data = '0;
      ifo.valid = 1'b0; ifo.data = '0;
      ifs.valid = 1'b0; ifs.data = '0;
      test_reset();
      test_basic();
      test_parity();
      test_burst();
      step();
      test_fifo_edges();
      test_reset_mid();
      test_small();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
